// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: service states, source priority, bus alignment.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DREAD = 2'd2,
    IREAD = 2'd3
  } state_t;

  localparam int NUM_SRC = 3;

  // Index 0 is served first.
  localparam state_t PRIO_ORDER [NUM_SRC] = '{WRITE, DREAD, IREAD};

  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic is_pending(input state_t st, input logic pw, input logic pd,
                                      input logic pi);
    logic r;
    case (st)
      WRITE:   r = pw;
      DREAD:   r = pd;
      IREAD:   r = pi;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Highest-priority pending service state, or IDLE when nothing is pending.
  function automatic state_t pick_state(input logic pw, input logic pd, input logic pi);
    state_t r;
    r = IDLE;
    if (is_pending(PRIO_ORDER[2], pw, pd, pi)) r = PRIO_ORDER[2];
    if (is_pending(PRIO_ORDER[1], pw, pd, pi)) r = PRIO_ORDER[1];
    if (is_pending(PRIO_ORDER[0], pw, pd, pi)) r = PRIO_ORDER[0];
    return r;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Per-transaction cycle counter; expired is high on the TIMEOUT-th enabled cycle since the last clear.
module bus_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction read, data read and data write onto one req/ack word bus, stalling the core
// via MEM_WAIT until every latched request is served; a watchdog aborts transactions that never ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA,
  output logic        BUS_ERR
);

  state_t      state;
  logic        pw, pd, pi;
  logic        lat_i, lat_d;
  logic [31:0] w_addr, w_data, d_addr, i_addr;
  logic        expired;

  logic        req_any;
  state_t      first_st, after_st;
  logic        pw_n, pd_n, pi_n;

  function automatic logic [31:0] svc_addr(input state_t st, input logic [31:0] wa,
                                           input logic [31:0] da, input logic [31:0] ia);
    logic [31:0] a;
    case (st)
      WRITE:   a = wa;
      DREAD:   a = da;
      default: a = ia;
    endcase
    return a & ADDR_ALIGN_MASK;
  endfunction

  always_comb begin
    req_any  = INST_RDEN | DATA_RDEN | DATA_WREN;
    first_st = pick_state(DATA_WREN, DATA_RDEN, INST_RDEN);
    pw_n     = pw & (state != WRITE);
    pd_n     = pd & (state != DREAD);
    pi_n     = pi & (state != IREAD);
    after_st = pick_state(pw_n, pd_n, pi_n);
  end

  // The counter restarts whenever the request is low, which covers every state entry.
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (!BUS_REQ),
    .enable (BUS_REQ),
    .expired(expired)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      pw          <= 1'b0;
      pd          <= 1'b0;
      pi          <= 1'b0;
      lat_i       <= 1'b0;
      lat_d       <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      d_addr      <= '0;
      i_addr      <= '0;
      MEM_WAIT    <= 1'b0;
      BUS_REQ     <= 1'b0;
      BUS_WE      <= 1'b0;
      BUS_ADDR    <= '0;
      BUS_WDATA   <= '0;
      BUS_ERR     <= 1'b0;
      INST_RVALID <= 1'b0;
      INST_ROADDR <= '0;
      INST_RDATA  <= '0;
      DATA_RVALID <= 1'b0;
      DATA_ROADDR <= '0;
      DATA_RDATA  <= '0;
    end else begin
      INST_RVALID <= 1'b0;
      DATA_RVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            w_addr    <= DATA_WADDR;
            w_data    <= DATA_WDATA;
            d_addr    <= DATA_RIADDR;
            i_addr    <= INST_RIADDR;
            pw        <= DATA_WREN;
            pd        <= DATA_RDEN;
            pi        <= INST_RDEN;
            lat_d     <= DATA_RDEN;
            lat_i     <= INST_RDEN;
            state     <= first_st;
            MEM_WAIT  <= 1'b1;
            BUS_REQ   <= 1'b1;
            BUS_ADDR  <= svc_addr(first_st, DATA_WADDR, DATA_RIADDR, INST_RIADDR);
            BUS_WE    <= (first_st == WRITE);
            BUS_WDATA <= DATA_WDATA;
          end
        end
        WRITE, DREAD, IREAD: begin
          if (!BUS_REQ) begin
            // Gap cycle after the previous transaction: present the next one.
            BUS_REQ   <= 1'b1;
            BUS_ADDR  <= svc_addr(state, w_addr, d_addr, i_addr);
            BUS_WE    <= (state == WRITE);
            BUS_WDATA <= w_data;
          end else if (BUS_ACK || expired) begin
            BUS_REQ <= 1'b0;
            BUS_WE  <= 1'b0;
            if (!BUS_ACK) BUS_ERR <= 1'b1;
            if (state == DREAD) DATA_RDATA <= BUS_ACK ? BUS_RDATA : 32'h0;
            if (state == IREAD) INST_RDATA <= BUS_ACK ? BUS_RDATA : 32'h0;
            pw    <= pw_n;
            pd    <= pd_n;
            pi    <= pi_n;
            state <= after_st;
            if (after_st == IDLE) begin
              MEM_WAIT    <= 1'b0;
              INST_RVALID <= lat_i;
              DATA_RVALID <= lat_d;
              if (lat_i) INST_ROADDR <= i_addr;
              if (lat_d) DATA_ROADDR <= d_addr;
              lat_i <= 1'b0;
              lat_d <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the core's MMU-facing ports.
- Merges the core's instruction-read, data-read and data-write requests onto one single-port word bus with a req/ack handshake.
- Returns read results in the core's RDEN/RVALID format and drives MEM_WAIT to stall the whole pipeline while the bus transaction sequence is in progress.
- Includes a per-transaction watchdog that aborts a hung bus.

Parameters:
- TIMEOUT, 255: cycles to wait for BUS_ACK before aborting a transaction (1..65535).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- INST_RDEN  in  1  instruction read request
- INST_RIADDR  in  32  instruction byte address
- INST_ROADDR  out  32  echoed address of the returned instruction
- INST_RVALID  out  1  instruction data valid (1-cycle pulse)
- INST_RDATA  out  32  instruction word
- DATA_RDEN  in  1  data read request
- DATA_RIADDR  in  32  data read byte address
- DATA_ROADDR  out  32  echoed data read address
- DATA_RVALID  out  1  data read valid (1-cycle pulse)
- DATA_RDATA  out  32  data read word
- DATA_WREN  in  1  data write request
- DATA_WADDR  in  32  data write byte address
- DATA_WDATA  in  32  data write word
- MEM_WAIT  out  1  pipeline stall
- BUS_REQ  out  1  bus request, held until ack or abort
- BUS_WE  out  1  1 = write transaction
- BUS_ADDR  out  32  word-aligned bus address
- BUS_WDATA  out  32  write data
- BUS_ACK  in  1  transaction complete (1-cycle pulse)
- BUS_RDATA  in  32  read data, valid with BUS_ACK
- BUS_ERR  out  1  sticky timeout flag

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; all pending flags clear; watchdog 0.
  - All outputs 0: MEM_WAIT, BUS_REQ, BUS_WE, BUS_ERR, both RVALIDs, ROADDRs, RDATAs, BUS_ADDR, BUS_WDATA.
- States: IDLE, WRITE, DREAD, IREAD. MEM_WAIT = (state != IDLE), registered alongside the state.
- IDLE, rising edge with any request high:
  - Latch addresses and write data.
  - Set pending flags pw/pd/pi from WREN/RDEN inputs.
  - Go to the highest-priority pending state: WRITE > DREAD > IREAD.
  - MEM_WAIT is therefore high from the cycle after the request.
- IDLE inputs are sampled only in IDLE; inputs during MEM_WAIT=1 are ignored. The core holds them under stall.
- Service state:
  - BUS_REQ=1.
  - BUS_ADDR = latched addr with [1:0] forced to 00.
  - BUS_WE=1 only in WRITE; BUS_WDATA = latched DATA_WDATA.
  - BUS_ADDR, BUS_WE and BUS_WDATA must stay stable while BUS_REQ=1.
- On BUS_ACK:
  - Clear that state's flag; in DREAD/IREAD capture BUS_RDATA into the result register.
  - Drop BUS_REQ for at least one cycle.
  - Go to the next pending state, else IDLE.
- Watchdog:
  - Counts cycles in each service state; reset on state entry.
  - Reaching TIMEOUT without ack: BUS_ERR set (sticky until reset), BUS_REQ dropped, flag cleared, read result = 32'h0, advance as if acked.
  - BUS_ACK in the same cycle the count hits TIMEOUT counts as success; no error.
- Return to IDLE:
  - In that same cycle, INST_RVALID/DATA_RVALID pulse for 1 cycle for each read that was latched.
  - ROADDR = original unmasked byte address; RDATA = captured word.
  - MEM_WAIT=0 in that cycle.
- A new request present on the RVALID cycle is latched normally (back-to-back allowed).
- No request in IDLE: remain in IDLE, BUS idle, no pulses.
- BUS_ACK while not in a service state: ignored.
- Reset mid-transaction: BUS_REQ drops immediately; pending requests are discarded.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, WRITE, DREAD, IREAD), priority order constant, ADDR_ALIGN_MASK = 32'hFFFF_FFFC.
- One sub-module: bus_watchdog (counter with clear/enable inputs, TIMEOUT parameter, expired output).

Test Plan:
- Single fetch: INST_RDEN=1, addr 0x0000_0106; bus acks after 3 cycles with 0x0010_0093 -> BUS_ADDR=0x0000_0104, BUS_WE=0; MEM_WAIT high for 4 cycles; INST_RVALID pulse with ROADDR=0x0000_0106, RDATA=0x0010_0093.
- All three requests in one cycle (W 0x200 data 0xDEAD_BEEF, DR 0x300, IR 0x100) -> bus order W, DR, IR; both RVALIDs pulse in the same cycle, after the third ack.
- Data read only, bus ack after 1 cycle with 0x1234_5678 -> DATA_RVALID pulse with DATA_RDATA=0x1234_5678; INST_RVALID stays 0.
- TIMEOUT=4, bus never acks a fetch -> BUS_REQ drops after 4 cycles; BUS_ERR=1 and stays 1; INST_RVALID pulse with RDATA=0.
- Back-to-back: new INST_RDEN on the RVALID cycle -> MEM_WAIT high the next cycle with no lost request; BUS_ACK with no request -> no effect.
- RST low during DREAD with BUS_REQ=1 -> BUS_REQ and MEM_WAIT 0 asynchronously; after release, no spurious RVALID pulse.
